// File: rtl/l2_cacheline_adapter.sv
// l2_cacheline_adapter
// Bridges the L2 cache physical-memory port (one 256-bit line per request)
// to a burst-mode memory that moves one 64-bit beat per strobed cycle.
//   clk, rst                 : clock and asynchronous active-high reset
//   line_i / line_o          : line written by L2 / line assembled for L2
//   address_i, read_i,
//   write_i, resp_o          : L2-side request (level) and one-cycle completion
//   burst_i / burst_o        : beat read from memory / beat written to memory
//   address_o, read_o,
//   write_o, resp_i          : memory-side burst base address, requests, beat strobe
module l2_cacheline_adapter #(
  parameter int s_offset  = 5,
  parameter int s_line    = 8 * (2 ** s_offset),
  parameter int s_burst   = 64,
  parameter int num_beats = s_line / s_burst
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int cnt_w = $clog2(num_beats);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [cnt_w-1:0]   count;
  logic [s_line-1:0]  wbuf;
  logic               last_beat;
  logic               accept_read;
  logic               accept_write;
  logic [31:0]        aligned_addr;

  // Line-aligned request address: byte-offset bits are forced to zero.
  assign aligned_addr = {address_i[31:s_offset], {s_offset{1'b0}}};
  assign last_beat    = (count == cnt_w'(num_beats - 1));

  // Next-state logic; a simultaneous read and write request is served as a read.
  always_comb begin
    state_next   = state;
    accept_read  = 1'b0;
    accept_write = 1'b0;
    case (state)
      IDLE: begin
        if (read_i) begin
          accept_read = 1'b1;
          state_next  = READ;
        end else if (write_i) begin
          accept_write = 1'b1;
          state_next   = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (resp_i && last_beat) begin
          state_next = DONE;
        end else begin
          state_next = READ;
        end
      end
      WRITE: begin
        if (resp_i && last_beat) begin
          state_next = DONE;
        end else begin
          state_next = WRITE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outgoing write beat follows the counter so beat 0 is visible on the first WRITE cycle.
  always_comb begin
    burst_o = {s_burst{1'b0}};
    if (state == WRITE) begin
      burst_o = wbuf[s_burst*count +: s_burst];
    end else begin
      burst_o = {s_burst{1'b0}};
    end
  end

  // State, beat counter, latched address/line and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= {cnt_w{1'b0}};
      wbuf      <= {s_line{1'b0}};
      line_o    <= {s_line{1'b0}};
      address_o <= 32'h0000_0000;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state <= state_next;
      // Handshake flags are registered copies of the state being entered.
      read_o  <= (state_next == READ);
      write_o <= (state_next == WRITE);
      resp_o  <= (state_next == DONE);

      if (accept_read || accept_write) begin
        address_o <= aligned_addr;
        count     <= {cnt_w{1'b0}};
      end else if (((state == READ) || (state == WRITE)) && resp_i) begin
        // Counter wraps back to zero after the last beat.
        count <= count + cnt_w'(1);
      end

      if (accept_write) begin
        wbuf <= line_i;
      end

      if ((state == READ) && resp_i) begin
        line_o[s_burst*count +: s_burst] <= burst_i;
      end
    end
  end

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
module tb_l2_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests;
  int failed;

  l2_cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serves a read already requested: four back-to-back beats, then checks DONE.
  task automatic run_read(input logic [255:0] line, input logic [31:0] exp_addr, input bit hold);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rd_read_o", {255'd0, read_o}, 256'd1);
      chk("rd_write_o", {255'd0, write_o}, 256'd0);
      chk("rd_resp_o", {255'd0, resp_o}, 256'd0);
      chk("rd_addr", {224'd0, address_o}, {224'd0, exp_addr});
      resp_i  = 1'b1;
      burst_i = line[64*k +: 64];
    end
    @(negedge clk);
    resp_i  = 1'b0;
    burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    chk("rd_done_resp", {255'd0, resp_o}, 256'd1);
    chk("rd_done_read_o", {255'd0, read_o}, 256'd0);
    chk("rd_line", line_o, line);
    if (!hold) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
  endtask

  logic [255:0] l1, l2, l3, wl, line_b;
  logic [7:0]   pat;
  int           nb;

  initial begin
    tests = 0; failed = 0;
    rst = 1'b1; line_i = 256'd0; address_i = 32'd0; read_i = 1'b0; write_i = 1'b0;
    burst_i = 64'd0; resp_i = 1'b0;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wl = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
          64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    l2 = {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
          64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    l3 = {64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF,
          64'hFEDC_BA98_7654_3210, 64'hCAFE_F00D_DEAD_BEEF};

    // Reset values
    @(negedge clk);
    chk("rst_read_o", {255'd0, read_o}, 256'd0);
    chk("rst_write_o", {255'd0, write_o}, 256'd0);
    chk("rst_resp_o", {255'd0, resp_o}, 256'd0);
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_burst_o", {192'd0, burst_o}, 256'd0);
    chk("rst_addr_o", {224'd0, address_o}, 256'd0);
    rst = 1'b0;

    // Basic read with unaligned address
    @(negedge clk);
    address_i = 32'h0000_12F7; read_i = 1'b1;
    run_read(l1, 32'h0000_12E0, 1'b0);
    @(negedge clk);
    chk("rd_after_resp", {255'd0, resp_o}, 256'd0);
    chk("rd_line_hold", line_o, l1);

    // Write; line_i and address_i change mid-burst
    line_i = wl; address_i = 32'h8000_0040; write_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wr_write_o", {255'd0, write_o}, 256'd1);
      chk("wr_read_o", {255'd0, read_o}, 256'd0);
      chk("wr_resp_o", {255'd0, resp_o}, 256'd0);
      chk("wr_burst", {192'd0, burst_o}, {192'd0, wl[64*k +: 64]});
      chk("wr_addr", {224'd0, address_o}, 256'h8000_0040);
      line_i    = ~wl;
      address_i = 32'h1234_5678;
      resp_i    = 1'b1;
    end
    @(negedge clk);
    resp_i = 1'b0; write_i = 1'b0;
    chk("wr_done_resp", {255'd0, resp_o}, 256'd1);
    chk("wr_done_write_o", {255'd0, write_o}, 256'd0);
    chk("wr_done_addr", {224'd0, address_o}, 256'h8000_0040);
    chk("wr_line_o_kept", line_o, l1);
    @(negedge clk);
    chk("wr_after_resp", {255'd0, resp_o}, 256'd0);

    // Stalled read: strobe pattern 1,0,0,1,1,0,1
    address_i = 32'hABCD_EF1F; read_i = 1'b1;
    pat = 8'b0101_1001;  // bit j = strobe in cycle j
    nb = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("st_read_o", {255'd0, read_o}, 256'd1);
      chk("st_resp_o", {255'd0, resp_o}, 256'd0);
      chk("st_addr", {224'd0, address_o}, 256'hABCD_EF00);
      resp_i = pat[j];
      if (pat[j]) begin
        burst_i = l2[64*nb +: 64];
        nb++;
      end else begin
        burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0;
    chk("st_done_resp", {255'd0, resp_o}, 256'd1);
    chk("st_line", line_o, l2);

    // Simultaneous read and write: read wins
    @(negedge clk);
    chk("st_after_resp", {255'd0, resp_o}, 256'd0);
    address_i = 32'h0000_0100; line_i = wl; read_i = 1'b1; write_i = 1'b1;
    run_read(l3, 32'h0000_0100, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rw_no_write", {255'd0, write_o}, 256'd0);
      chk("rw_idle_resp", {255'd0, resp_o}, 256'd0);
    end

    // Asynchronous reset after two beats of a read
    address_i = 32'h0000_0200; read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1; burst_i = l1[63:0];
    @(negedge clk);
    resp_i = 1'b1; burst_i = l1[127:64];
    @(negedge clk);
    resp_i = 1'b0;
    chk("ar_read_o_pre", {255'd0, read_o}, 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_read_o", {255'd0, read_o}, 256'd0);
    chk("ar_resp_o", {255'd0, resp_o}, 256'd0);
    chk("ar_line_o", line_o, 256'd0);
    chk("ar_addr_o", {224'd0, address_o}, 256'd0);
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("ar_no_resp", {255'd0, resp_o}, 256'd0);
      chk("ar_idle_read", {255'd0, read_o}, 256'd0);
    end
    address_i = 32'h0000_0300; read_i = 1'b1;
    run_read(l2, 32'h0000_0300, 1'b0);

    // Back-to-back: read_i held one cycle past resp_o
    @(negedge clk);
    address_i = 32'h0000_0400; read_i = 1'b1;
    run_read(l1, 32'h0000_0400, 1'b1);
    @(negedge clk);
    chk("bb_idle_read", {255'd0, read_o}, 256'd0);
    chk("bb_idle_resp", {255'd0, resp_o}, 256'd0);
    run_read(l3, 32'h0000_0400, 1'b0);
    line_b = l3;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bb_stay_idle", {255'd0, read_o}, 256'd0);
      chk("bb_no_resp", {255'd0, resp_o}, 256'd0);
      chk("bb_line_hold", line_o, line_b);
      resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    @(negedge clk);
    resp_i = 1'b0;
    chk("bb_final_resp", {255'd0, resp_o}, 256'd0);
    chk("bb_final_line", line_o, line_b);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
